// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, widths and the ID/EX pipeline register layout
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RADDR_W = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  typedef struct packed {
    logic valid;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_DATA_W-1:0] pc4;
    logic [DEF_RADDR_W-1:0] rs;
    logic [DEF_RADDR_W-1:0] rt;
    logic [DEF_RADDR_W-1:0] rd;
    logic [5:0] opcode;
    logic [5:0] funct;
  } idex_t;
endpackage

// File: rtl/forward_mux.sv
// forward_mux: per-operand priority select between r0, EX, MEM, WB and register file
module forward_mux #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W,
  parameter int RADDR_W = mips_pkg::DEF_RADDR_W
) (
  input  logic [RADDR_W-1:0] src,
  input  logic [DATA_W-1:0]  rf_rd,
  input  logic               ex_we,
  input  logic               ex_is_load,
  input  logic [RADDR_W-1:0] ex_wa,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_wa,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  val
);
  // youngest producer wins; a load in EX has no data yet, so it is skipped here and stalled elsewhere
  always_comb begin
    val = (src == '0) ? '0 :
          (ex_we && ex_wa == src && !ex_is_load) ? ex_result :
          (mem_we && mem_wa == src) ? mem_result :
          (wb_we && wb_wa == src) ? wb_data : rf_rd;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode operands, forward, detect load-use and fill the ID/EX register
module operand_fetch_stage import mips_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_instr,
  input  logic [DATA_W-1:0]  id_pc4,
  output logic [RADDR_W-1:0] rf_ra1,
  output logic [RADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0]  rf_rd1,
  input  logic [DATA_W-1:0]  rf_rd2,
  input  logic               ex_we,
  input  logic               ex_is_load,
  input  logic [RADDR_W-1:0] ex_wa,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_wa,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               stall_id,
  output logic               idex_valid,
  output logic [DATA_W-1:0]  idex_a,
  output logic [DATA_W-1:0]  idex_b,
  output logic [DATA_W-1:0]  idex_imm,
  output logic [DATA_W-1:0]  idex_pc4,
  output logic [RADDR_W-1:0] idex_rs,
  output logic [RADDR_W-1:0] idex_rt,
  output logic [RADDR_W-1:0] idex_rd,
  output logic [5:0]         idex_opcode,
  output logic [5:0]         idex_funct
);
  logic [5:0] op;
  logic rs_used, rt_used, hazard;
  logic [DATA_W-1:0] imm, fwd_a, fwd_b;
  idex_t r, nxt;
  assign op = id_instr[31:26];
  assign rf_ra1 = id_instr[25:21];
  assign rf_ra2 = id_instr[20:16];
  forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_a (
    .src(rf_ra1), .rf_rd(rf_rd1), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa),
    .ex_result(ex_result), .mem_we(mem_we), .mem_wa(mem_wa), .mem_result(mem_result),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_data(wb_data), .val(fwd_a)
  );
  forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_b (
    .src(rf_ra2), .rf_rd(rf_rd2), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa),
    .ex_result(ex_result), .mem_we(mem_we), .mem_wa(mem_wa), .mem_result(mem_result),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_data(wb_data), .val(fwd_b)
  );
  // operand usage, load-use detection and immediate extension
  always_comb begin
    rs_used = !(op == OP_J || op == OP_JAL || op == OP_LUI);
    rt_used = op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    hazard = id_valid && ex_we && ex_is_load && ex_wa != '0 &&
             ((rs_used && ex_wa == rf_ra1) || (rt_used && ex_wa == rf_ra2));
    stall_id = hazard || ex_hold;
    imm = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? {16'h0, id_instr[15:0]} :
          {{16{id_instr[15]}}, id_instr[15:0]};
    nxt = '{valid: id_valid, a: fwd_a, b: fwd_b, imm: imm, pc4: id_pc4, rs: rf_ra1,
            rt: rf_ra2, rd: id_instr[15:11], opcode: op, funct: id_instr[5:0]};
  end
  // ID/EX register: hold beats flush beats bubble beats normal load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r <= '0;
    else if (ex_hold) r <= r;
    else if (flush || hazard) r.valid <= 1'b0;
    else r <= nxt;
  end
  assign idex_valid = r.valid;
  assign idex_a = r.a;
  assign idex_b = r.b;
  assign idex_imm = r.imm;
  assign idex_pc4 = r.pc4;
  assign idex_rs = r.rs;
  assign idex_rt = r.rt;
  assign idex_rd = r.rd;
  assign idex_opcode = r.opcode;
  assign idex_funct = r.funct;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed checks of forwarding, stalls, immediates, hold and flush
module tb_operand_fetch_stage;
  logic clk = 0, reset_n = 0, id_valid, ex_we, ex_is_load, mem_we, wb_we, flush, ex_hold;
  logic [31:0] id_instr, id_pc4, rf_rd1, rf_rd2, ex_result, mem_result, wb_data;
  logic [4:0] ex_wa, mem_wa, wb_wa, rf_ra1, rf_ra2;
  logic stall_id, idex_valid;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc4;
  logic [4:0] idex_rs, idex_rt, idex_rd;
  logic [5:0] idex_opcode, idex_funct;
  int checks = 0, failures = 0;
  operand_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_result(mem_result),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold),
    .stall_id(stall_id), .idex_valid(idex_valid), .idex_a(idex_a), .idex_b(idex_b),
    .idex_imm(idex_imm), .idex_pc4(idex_pc4), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_rd(idex_rd), .idex_opcode(idex_opcode), .idex_funct(idex_funct)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  task automatic quiet;
    id_valid = 0; id_instr = 0; id_pc4 = 0; rf_rd1 = 0; rf_rd2 = 0;
    ex_we = 0; ex_is_load = 0; ex_wa = 0; ex_result = 0;
    mem_we = 0; mem_wa = 0; mem_result = 0; wb_we = 0; wb_wa = 0; wb_data = 0;
    flush = 0; ex_hold = 0;
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    quiet();
    tick();
    checks++; if (idex_valid !== 1'b0 || idex_a !== 32'h0 || idex_pc4 !== 32'h0) begin failures++; $display("FAIL reset_state valid=%b a=%h pc4=%h exp 0", idex_valid, idex_a, idex_pc4); end
    @(negedge clk); reset_n = 1; id_valid = 1; id_instr = rtype(1, 2, 3, 6'h20); id_pc4 = 32'h104; rf_rd1 = 32'h99; rf_rd2 = 32'h5;
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_a !== 32'h99 || idex_pc4 !== 32'h104) begin failures++; $display("FAIL pre_reset_load valid=%b a=%h pc4=%h exp 1/99/104", idex_valid, idex_a, idex_pc4); end
    #1 reset_n = 0; #1;
    checks++; if (idex_valid !== 1'b0 || idex_a !== 32'h0 || idex_pc4 !== 32'h0) begin failures++; $display("FAIL async_reset valid=%b a=%h pc4=%h exp 0", idex_valid, idex_a, idex_pc4); end
    @(negedge clk); reset_n = 1; id_valid = 0;
    tick();
    checks++; if (idex_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got %b exp 0", idex_valid); end
  endtask
  task automatic test_ex_forward;
    @(negedge clk); quiet(); id_valid = 1; id_instr = rtype(5, 5, 1, 6'h20); id_pc4 = 32'h200;
    rf_rd1 = 32'h11; rf_rd2 = 32'h11; ex_we = 1; ex_wa = 5; ex_result = 32'h22;
    mem_we = 1; mem_wa = 5; mem_result = 32'h33; wb_we = 1; wb_wa = 5; wb_data = 32'h44;
    #1;
    checks++; if (rf_ra1 !== 5'd5 || rf_ra2 !== 5'd5) begin failures++; $display("FAIL read_addr ra1=%0d ra2=%0d exp 5/5", rf_ra1, rf_ra2); end
    tick();
    checks++; if (idex_a !== 32'h22 || idex_b !== 32'h22) begin failures++; $display("FAIL ex_fwd a=%h b=%h exp 22/22", idex_a, idex_b); end
    checks++; if (idex_rd !== 5'd1 || idex_funct !== 6'h20 || idex_pc4 !== 32'h200 || idex_opcode !== 6'h00) begin failures++; $display("FAIL ex_fwd_fields rd=%0d funct=%h pc4=%h op=%h exp 1/20/200/0", idex_rd, idex_funct, idex_pc4, idex_opcode); end
    @(negedge clk); ex_we = 0;
    tick();
    checks++; if (idex_a !== 32'h33) begin failures++; $display("FAIL mem_fwd a=%h exp 33", idex_a); end
    @(negedge clk); mem_we = 0;
    tick();
    checks++; if (idex_a !== 32'h44) begin failures++; $display("FAIL wb_over_rf a=%h exp 44", idex_a); end
  endtask
  task automatic test_wb_bypass;
    @(negedge clk); quiet(); id_valid = 1; id_instr = itype(6'h08, 7, 2, 16'h5);
    wb_we = 1; wb_wa = 7; wb_data = 32'hDEAD; rf_rd1 = 32'h0;
    tick();
    checks++; if (idex_a !== 32'hDEAD || idex_rs !== 5'd7) begin failures++; $display("FAIL wb_bypass a=%h rs=%0d exp dead/7", idex_a, idex_rs); end
    @(negedge clk); id_instr = itype(6'h08, 0, 2, 16'h5); wb_wa = 0; rf_rd1 = 32'h77; ex_we = 1; ex_wa = 0; ex_result = 32'h44;
    tick();
    checks++; if (idex_a !== 32'h0) begin failures++; $display("FAIL r0_zero a=%h exp 0", idex_a); end
  endtask
  task automatic test_load_use;
    @(negedge clk); quiet(); id_valid = 1; id_instr = rtype(4, 3, 2, 6'h20); rf_rd1 = 32'h0; rf_rd2 = 32'h3;
    ex_we = 1; ex_is_load = 1; ex_wa = 4; ex_result = 32'hBAD;
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_stall got %b exp 1", stall_id); end
    tick();
    checks++; if (idex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble valid=%b exp 0", idex_valid); end
    @(negedge clk); ex_we = 0; ex_is_load = 0; mem_we = 1; mem_wa = 4; mem_result = 32'h55;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_release stall=%b exp 0", stall_id); end
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_a !== 32'h55 || idex_b !== 32'h3) begin failures++; $display("FAIL lu_resume valid=%b a=%h b=%h exp 1/55/3", idex_valid, idex_a, idex_b); end
    @(negedge clk); quiet(); id_valid = 1; id_instr = itype(6'h2B, 1, 4, 16'h0); ex_we = 1; ex_is_load = 1; ex_wa = 4;
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_sw_rt stall=%b exp 1", stall_id); end
    id_instr = itype(6'h08, 1, 4, 16'h0);
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_addi_rt stall=%b exp 0", stall_id); end
    id_instr = rtype(0, 3, 2, 6'h20); ex_wa = 0;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_r0 stall=%b exp 0", stall_id); end
    id_instr = rtype(4, 3, 2, 6'h20); ex_wa = 4; id_valid = 0;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_invalid stall=%b exp 0", stall_id); end
  endtask
  task automatic test_no_false_stall;
    @(negedge clk); quiet(); id_valid = 1; id_instr = {6'h02, 26'h0800100}; ex_we = 1; ex_is_load = 1; ex_wa = 4;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL j_stall got %b exp 0", stall_id); end
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_opcode !== 6'h02) begin failures++; $display("FAIL j_valid valid=%b op=%h exp 1/02", idex_valid, idex_opcode); end
    @(negedge clk); id_instr = itype(6'h0F, 4, 4, 16'h1234);
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lui_stall got %b exp 0", stall_id); end
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_imm !== 32'h00001234) begin failures++; $display("FAIL lui_imm valid=%b imm=%h exp 1/00001234", idex_valid, idex_imm); end
  endtask
  task automatic test_imm;
    @(negedge clk); quiet(); id_valid = 1; id_instr = itype(6'h0D, 1, 2, 16'h8000);
    tick();
    checks++; if (idex_imm !== 32'h00008000) begin failures++; $display("FAIL ori_imm got %h exp 00008000", idex_imm); end
    @(negedge clk); id_instr = itype(6'h08, 1, 2, 16'h8000);
    tick();
    checks++; if (idex_imm !== 32'hFFFF8000) begin failures++; $display("FAIL addi_imm got %h exp ffff8000", idex_imm); end
    @(negedge clk); id_instr = itype(6'h0C, 1, 2, 16'hFFFF);
    tick();
    checks++; if (idex_imm !== 32'h0000FFFF) begin failures++; $display("FAIL andi_imm got %h exp 0000ffff", idex_imm); end
  endtask
  task automatic test_hold_flush;
    @(negedge clk); quiet(); id_valid = 1; id_instr = itype(6'h08, 1, 2, 16'h10); rf_rd1 = 32'hAA;
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_a !== 32'hAA) begin failures++; $display("FAIL hold_setup valid=%b a=%h exp 1/aa", idex_valid, idex_a); end
    @(negedge clk); ex_hold = 1; flush = 1; id_instr = rtype(3, 4, 5, 6'h22); rf_rd1 = 32'hBB;
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL hold_stall got %b exp 1", stall_id); end
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_a !== 32'hAA || idex_rs !== 5'd1 || idex_imm !== 32'h10) begin failures++; $display("FAIL hold_keep valid=%b a=%h rs=%0d imm=%h exp 1/aa/1/10", idex_valid, idex_a, idex_rs, idex_imm); end
    @(negedge clk); ex_hold = 0;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL flush_stall got %b exp 0", stall_id); end
    tick();
    checks++; if (idex_valid !== 1'b0) begin failures++; $display("FAIL flush_kill valid=%b exp 0", idex_valid); end
    @(negedge clk); flush = 0;
    tick();
    checks++; if (idex_valid !== 1'b1 || idex_a !== 32'hBB || idex_funct !== 6'h22) begin failures++; $display("FAIL after_flush valid=%b a=%h funct=%h exp 1/bb/22", idex_valid, idex_a, idex_funct); end
  endtask
  initial begin
    test_reset();
    test_ex_forward();
    test_wb_bypass();
    test_load_use();
    test_no_false_stall();
    test_imm();
    test_hold_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
